// File: rtl/alu_share_arb.sv
// Two-requester arbiter sharing one saturating ALU: round-robin grant, one-cycle registered
// result return with per-requester backpressure. Define ALU_ARB_FIXED_PRIO_EN for fixed priority plus starvation guard.
module alu_share_arb #(
  parameter int DATA_W  = 16,
  parameter int OPS_W   = 3,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [OPS_W-1:0]   req0_ops,
  input  logic [DATA_W-1:0]  req0_src1,
  input  logic [DATA_W-1:0]  req0_src0,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [OPS_W-1:0]   req1_ops,
  input  logic [DATA_W-1:0]  req1_src1,
  input  logic [DATA_W-1:0]  req1_src0,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic [1:0]         gnt,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [DATA_W-1:0]  resp0_data,
  output logic [DATA_W-1:0]  resp1_data,
  output logic [OPS_W-1:0]   alu_ops,
  output logic [DATA_W-1:0]  alu_src1,
  output logic [DATA_W-1:0]  alu_src0,
  output logic [SHAMT_W-1:0] alu_shamt,
  input  logic [DATA_W-1:0]  alu_dst,
  output logic               alu_flag_hold,
  output logic [7:0]         busy_cnt
);

  localparam logic [OPS_W-1:0] IDLE_OP = OPS_W'(2);

  logic [1:0] elig;

  // A requester whose previous result is still unconsumed may not issue again.
  assign elig = req_valid & (~resp_valid | resp_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic [3:0] starve_cnt;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (elig[1] && (!elig[0] || starve_cnt == 4'hF)) gnt = 2'b10;
      else if (elig[0])                                gnt = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                   starve_cnt <= '0;
    else if (gnt[1])                           starve_cnt <= '0;
    else if (elig[1] && starve_cnt != 4'hF)    starve_cnt <= starve_cnt + 4'd1;
  end
`else
  logic prio_ptr;

  // NOTE: every default is assigned before the branches so no path leaves gnt unassigned (no latch).
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (elig == 2'b11) gnt = prio_ptr ? 2'b10 : 2'b01;
      else               gnt = elig;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)         prio_ptr <= 1'b0;
    else if (gnt[0]) prio_ptr <= 1'b1;
    else if (gnt[1]) prio_ptr <= 1'b0;
  end
`endif

  always_comb begin
    alu_ops   = IDLE_OP;
    alu_src1  = '0;
    alu_src0  = '0;
    alu_shamt = '0;
    if (gnt[1]) begin
      alu_ops   = req1_ops;
      alu_src1  = req1_src1;
      alu_src0  = req1_src0;
      alu_shamt = req1_shamt;
    end else if (gnt[0]) begin
      alu_ops   = req0_ops;
      alu_src1  = req0_src1;
      alu_src0  = req0_src0;
      alu_shamt = req0_shamt;
    end
  end

  // Only the execute stage owns the N/Z/V flags; secondary and idle ops are masked.
  assign alu_flag_hold = ~gnt[0];

  // NOTE: result data registers are reset too, so a stale value never appears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 2'b00;
      resp0_data <= '0;
      resp1_data <= '0;
    end else begin
      if (gnt[0]) begin
        resp_valid[0] <= 1'b1;
        resp0_data    <= alu_dst;
      end else if (resp_ready[0]) begin
        resp_valid[0] <= 1'b0;
      end
      if (gnt[1]) begin
        resp_valid[1] <= 1'b1;
        resp1_data    <= alu_dst;
      end else if (resp_ready[1]) begin
        resp_valid[1] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                         busy_cnt <= '0;
    else if ((|(req_valid & ~gnt)) && busy_cnt != 8'hFF) busy_cnt <= busy_cnt + 8'd1;
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU stub and a per-requester result scoreboard.
// Covers reset, arbitration, flag hold, backpressure, mid-op reset and ALU_ARB_FIXED_PRIO_EN when defined.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [2:0]  req0_ops, req1_ops;
  logic [15:0] req0_src1, req0_src0, req1_src1, req1_src0;
  logic [3:0]  req0_shamt, req1_shamt;
  logic [1:0]  gnt, resp_valid, resp_ready;
  logic [15:0] resp0_data, resp1_data;
  logic [2:0]  alu_ops;
  logic [15:0] alu_src1, alu_src0, alu_dst;
  logic [3:0]  alu_shamt;
  logic        alu_flag_hold;
  logic [7:0]  busy_cnt;

  logic [18:0] alu_out;
  logic        tb_n = 1'b0, tb_z = 1'b0, tb_v = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [1:0]  last_gnt = 2'b00;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req0_ops(req0_ops), .req0_src1(req0_src1), .req0_src0(req0_src0), .req0_shamt(req0_shamt),
    .req1_ops(req1_ops), .req1_src1(req1_src1), .req1_src0(req1_src0), .req1_shamt(req1_shamt),
    .gnt(gnt), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp0_data(resp0_data), .resp1_data(resp1_data),
    .alu_ops(alu_ops), .alu_src1(alu_src1), .alu_src0(alu_src0), .alu_shamt(alu_shamt),
    .alu_dst(alu_dst), .alu_flag_hold(alu_flag_hold), .busy_cnt(busy_cnt)
  );

  // Returns {N, Z, V, result}; src1 is the left operand.
  function automatic logic [18:0] alu_model(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [3:0] sh);
    logic [15:0] r;
    logic [15:0] s;
    logic        v;
    r = '0;
    s = '0;
    v = 1'b0;
    case (op)
      3'b000: begin
        s = a + b;
        v = (a[15] == b[15]) && (s[15] != a[15]);
        r = v ? (a[15] ? 16'h8000 : 16'h7FFF) : s;
      end
      3'b001: begin
        s = a - b;
        v = (a[15] != b[15]) && (s[15] != a[15]);
        r = v ? (a[15] ? 16'h8000 : 16'h7FFF) : s;
      end
      3'b010:  r = a & b;
      3'b011:  r = ~(a | b);
      3'b100:  r = a << sh;
      3'b101:  r = a >> sh;
      3'b110:  r = 16'($signed(a) >>> sh);
      default: r = {b[7:0], a[7:0]};
    endcase
    return {r[15], (r == 16'h0000), v, r};
  endfunction

  always_comb alu_out = alu_model(alu_ops, alu_src1, alu_src0, alu_shamt);
  assign alu_dst = alu_out[15:0];

  always @(posedge clk)
    if (!alu_flag_hold) {tb_n, tb_z, tb_v} <= alu_out[18:16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic [18:0] m;
    @(negedge clk);
    if (last_gnt[0]) begin
      check("resp0_valid_after_gnt", resp_valid[0], 1);
      if (q0.size() > 0) check("sb_resp0_data", resp0_data, q0.pop_front());
    end
    if (last_gnt[1]) begin
      check("resp1_valid_after_gnt", resp_valid[1], 1);
      if (q1.size() > 0) check("sb_resp1_data", resp1_data, q1.pop_front());
    end
    last_gnt = gnt;
    if (gnt[0]) begin
      m = alu_model(req0_ops, req0_src1, req0_src0, req0_shamt);
      q0.push_back(m[15:0]);
    end
    if (gnt[1]) begin
      m = alu_model(req1_ops, req1_src1, req1_src0, req1_shamt);
      q1.push_back(m[15:0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] sh);
    req0_ops = op; req0_src1 = a; req0_src0 = b; req0_shamt = sh;
  endtask

  task automatic set_req1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] sh);
    req1_ops = op; req1_src1 = a; req1_src0 = b; req1_shamt = sh;
  endtask

  initial begin
    logic [1:0] exp_g;
    logic [1:0] g;

    // Reset with both requesting: nothing may be granted, flags held.
    rst = 1'b1;
    req_valid = 2'b11;
    resp_ready = 2'b11;
    set_req0(3'b000, 16'h1111, 16'h2222, 4'h0);
    set_req1(3'b000, 16'h3333, 16'h4444, 4'h0);
    #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_flag_hold", alu_flag_hold, 1);
    tick();
    tick();
    rst = 1'b0;
    req_valid = 2'b00;
    #1;
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_busy_cnt", busy_cnt, 0);
    check("rst_resp0_data", resp0_data, 16'h0000);
    check("rst_resp1_data", resp1_data, 16'h0000);
    check("idle_alu_ops", alu_ops, 3'b010);
    check("idle_alu_src1", alu_src1, 16'h0000);

    // Requester 0 saturating add.
    set_req0(3'b000, 16'h7000, 16'h2000, 4'h0);
    req_valid = 2'b01;
    #1;
    check("r0_gnt", gnt, 2'b01);
    check("r0_flag_hold", alu_flag_hold, 0);
    check("r0_alu_src1", alu_src1, 16'h7000);
    tick();
    req_valid = 2'b00;
    #1;
    check("r0_resp_valid", resp_valid, 2'b01);
    check("r0_resp0_data", resp0_data, 16'h7FFF);
    check("r0_flag_v", tb_v, 1);
    check("r0_busy_cnt", busy_cnt, 0);

    // Requester 1 subtract to zero must leave flags untouched.
    set_req1(3'b001, 16'h0005, 16'h0005, 4'h0);
    req_valid = 2'b10;
    #1;
    check("r1_gnt", gnt, 2'b10);
    check("r1_flag_hold", alu_flag_hold, 1);
    tick();
    req_valid = 2'b00;
    #1;
    check("r1_resp_valid1", resp_valid[1], 1);
    check("r1_resp1_data", resp1_data, 16'h0000);
    check("r1_flag_z_kept", tb_z, 0);
    check("r1_flag_v_kept", tb_v, 1);

    // Continuous contention; busy_cnt saturates after 255 denied cycles.
    req_valid = 2'b11;
    for (int k = 0; k < 264; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = (k % 16 == 15) ? 2'b10 : 2'b01;
`else
      exp_g = k[0] ? 2'b10 : 2'b01;
`endif
      #1;
      check($sformatf("contend_gnt%0d", k), gnt, exp_g);
      g = gnt;
      tick();
      if (k < 4) check($sformatf("contend_busy%0d", k), busy_cnt, k + 1);
      if (g[0]) set_req0(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
      if (g[1]) set_req1(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
    end
    check("busy_saturated", busy_cnt, 255);

    // Backpressure on requester 0: requester 1 owns the ALU, requester 0 data held.
    set_req0(3'b100, 16'h0003, 16'h0000, 4'h4);
    set_req1(3'b011, 16'h00F0, 16'h0F00, 4'h0);
    resp_ready = 2'b10;
    #1;
    check("bp_first_gnt", gnt, 2'b01);
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_gnt%0d", k), gnt, 2'b10);
      tick();
      check($sformatf("bp_resp0_valid%0d", k), resp_valid[0], 1);
      check($sformatf("bp_resp0_data%0d", k), resp0_data, 16'h0030);
    end
    resp_ready = 2'b11;
    #1;
    check("bp_release_gnt", gnt, 2'b01);
    tick();

    // Reset must restore the priority pointer after a requester 0 grant.
    req_valid = 2'b01;
    #1;
    check("pre_rst_gnt0", gnt, 2'b01);
    tick();
    rst = 1'b1;
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    check("post_rst_ptr_gnt", gnt, 2'b01);
    tick();

    // Reset in the cycle after a requester 1 grant.
    req_valid = 2'b10;
    #1;
    check("mid_gnt1", gnt, 2'b10);
    tick();
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    check("mid_rst_gnt", gnt, 2'b00);
    check("mid_rst_hold", alu_flag_hold, 1);
    tick();
    rst = 1'b0;
    req_valid = 2'b00;
    #1;
    check("mid_rst_resp_valid", resp_valid, 2'b00);
    check("mid_rst_busy", busy_cnt, 0);
    check("mid_rst_resp1_data", resp1_data, 16'h0000);
    check("mid_rst_gnt_idle", gnt, 2'b00);
    req_valid = 2'b11;
    #1;
    check("mid_rst_first_contend", gnt, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("sb_q0_drained", q0.size(), 0);
    check("sb_q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one 16-bit saturating ALU (add/sub/and/nor/sll/srl/sra/lhb, N/Z/V flag register with hold input) between two requesters.
  - Requester 0: the main pipeline execute stage.
  - Requester 1: a secondary unit, e.g. address-generation or debug.
- Round-robin arbitration, valid/grant request handshake, registered one-cycle result return with per-requester backpressure.
- Only requester 0 operations may update the ALU flag register.

Parameters:
- DATA_W, 16, operand/result width.
- OPS_W, 3, ALU opcode width.
- SHAMT_W, 4, shift amount width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req0_ops / req1_ops  in  OPS_W  opcode.
- req0_src1 / req1_src1  in  DATA_W  operand src1.
- req0_src0 / req1_src0  in  DATA_W  operand src0.
- req0_shamt / req1_shamt  in  SHAMT_W  shift amount.
- gnt  out  2  one-hot grant; request accepted this cycle.
- resp_valid  out  2  result valid per requester.
- resp_ready  in  2  requester accepts result.
- resp0_data / resp1_data  out  DATA_W  registered result.
- alu_ops  out  OPS_W  to ALU.
- alu_src1, alu_src0  out  DATA_W  to ALU.
- alu_shamt  out  SHAMT_W  to ALU.
- alu_dst  in  DATA_W  ALU combinational result.
- alu_flag_hold  out  1  to ALU flag-hold input; 1 = N/Z/V keep value.
- busy_cnt  out  8  saturating count of cycles a valid request was denied.

Behaviour:
- Eligibility: requester i is eligible when req_valid[i] && (!resp_valid[i] || resp_ready[i]).
- Arbitration (combinational, same cycle):
  - One eligible requester: it is granted.
  - Both eligible: the one pointed to by prio_ptr is granted.
  - None eligible: gnt=0.
- At most one gnt bit is ever set.
- Priority pointer:
  - On a cycle with gnt[i]=1, prio_ptr <= ~i at the edge.
  - Unchanged when there is no grant.
  - Reset value 0 (requester 0 favoured first).
- ALU drive:
  - gnt[i]=1: alu_* = requester i fields.
  - No grant: alu_ops=3'b010 (and), sources 0, shamt 0. This is a deterministic idle op, masked by hold.
- Flag hold:
  - alu_flag_hold = !gnt[0] (combinational).
  - Flags update only on the edge closing a granted requester 0 op.
  - Requester 1 ops and idle cycles never disturb N/Z/V.
- Request handshake: requester holds req_valid and operands stable until gnt seen; gnt is the accept strobe.
- Latency:
  - Grant in cycle T; alu_dst captured into respi_data at the edge ending T.
  - resp_valid[i]=1 from cycle T+1.
- Response register:
  - resp_valid[i] stays 1 and data stable until a cycle with resp_ready[i]=1.
  - Cleared at that edge unless a new grant to i occurs in the same cycle; then it stays 1 with new data (back-to-back throughput 1/cycle).
- Backpressure: while resp_valid[i] && !resp_ready[i], requester i is not granted; the other requester may use the ALU every cycle.
- busy_cnt increments on each cycle with any req_valid[i]=1 && gnt[i]=0; saturates at 255.
- Reset (any cycle, including mid-op):
  - gnt=0, resp_valid=0, resp data=0, prio_ptr=0, busy_cnt=0.
  - alu_flag_hold=1 while rst is high; a reset-cycle request is not granted.
- Ops are passed through unchanged; saturation, shift and lhb semantics are entirely the ALU's.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined:
  - Requester 0 always wins when both are eligible; prio_ptr is removed.
  - A 4-bit starvation counter on requester 1 increments each cycle requester 1 is eligible but denied.
  - At count 15, requester 1 is forced granted for one cycle, then the counter clears.
- Undefined: round-robin as above; no starvation counter.

Test Plan:
- Single request, requester 0 ops=000, src1=0x7000, src0=0x2000:
  - gnt=01 same cycle, alu_flag_hold=0.
  - Next cycle resp_valid=01, resp0_data=0x7FFF; ALU V=1.
- Both valid continuously, resp_ready=11, after reset:
  - gnt sequence 01,10,01,10.
  - busy_cnt increments by 1 per cycle.
- Requester 1 only, ops=001, src1=0x0005, src0=0x0005 (result 0x0000):
  - resp1_data=0x0000; alu_flag_hold=1 in grant cycle; ALU Z unchanged from prior value.
- Requester 0 resp_ready=0 with result pending, both valid:
  - Requester 0 never granted; requester 1 granted every cycle.
  - resp0_data held stable.
  - Raising resp_ready[0] lets requester 0 win next arbitration.
- Assert rst in the cycle after a grant to requester 1:
  - Next cycle resp_valid=00, gnt=00, busy_cnt=0; first post-reset contention grants requester 0.
- With ALU_ARB_FIXED_PRIO_EN, both valid continuously:
  - Requester 0 granted 15 consecutive cycles, requester 1 granted on the 16th, pattern repeats.
